// File: rtl/man_pkg.sv
// Shared types for the Manchester transmit path: FSM state encoding and line polarity.
package man_pkg;
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  // A 0 bit is sent high-then-low on the line.
  localparam logic MAN_ZERO_FIRST = 1'b1;
endpackage

// File: rtl/man_encoder_hb.sv
// Half-bit Manchester encoder: maps NRZ bit and phase to the line level.
// Purely combinational; the parent registers the result, and there is no backpressure.
module man_encoder_hb
  import man_pkg::*;
(
  input  logic nrz,
  input  logic phase,
  output logic man
);
  assign man = nrz ^ phase ^ MAN_ZERO_FIRST;
endmodule

// File: rtl/man_tx_ctrl.sv
// Manchester transmit sequencer: preamble, LSB-first words with optional parity, then idle gap.
// The line appears one cycle after accept; in_ready opens only in IDLE or in the last half-bit of a word.
module man_tx_ctrl
  import man_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 8,
  parameter int PARITY_EN    = 1,
  parameter int IDLE_GAP     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              man,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done
);
  localparam int CNT_MAX = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = $clog2(IDLE_GAP + 1);

  state_t            state, state_n;
  logic              phase, phase_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic              par, par_n;
  logic [GW-1:0]     gap_cnt, gap_cnt_n;
  logic              rst_done;
  logic              idle_rdy, last_bit;
  logic              nrz_n, enc_man, tx_en_n;

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    sreg_n     = sreg;
    par_n      = par;
    gap_cnt_n  = gap_cnt;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    idle_rdy   = (state == IDLE) && rst_done && (gap_cnt == '0);
    last_bit   = (state == PAR) ||
                 ((state == DATA) && (bit_cnt == CW'(DATA_W - 1)) && (PARITY_EN == 0));

    case (state)
      IDLE: begin
        in_ready = idle_rdy;
        if (in_valid && idle_rdy) begin
          state_n   = PRE;
          phase_n   = 1'b0;
          bit_cnt_n = '0;
          sreg_n    = in_data;
          par_n     = 1'b0;
        end
      end
      PRE: begin
        phase_n = ~phase;
        if (phase) begin
          if (bit_cnt == CW'(PREAMBLE_LEN - 1)) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      DATA: begin
        phase_n = ~phase;
        if (phase) begin
          sreg_n = sreg >> 1;
          par_n  = par ^ sreg[0];
          if (bit_cnt == CW'(DATA_W - 1)) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) state_n = PAR;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      PAR: phase_n = ~phase;
      GAP: begin
        gap_cnt_n = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) begin
          state_n   = IDLE;
          gap_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Word boundary: either chain the next word straight into DATA or close the frame.
    if (last_bit && phase) begin
      in_ready = 1'b1;
      if (in_valid) begin
        state_n   = DATA;
        bit_cnt_n = '0;
        sreg_n    = in_data;
        par_n     = 1'b0;
      end else begin
        frame_done = 1'b1;
        state_n    = GAP;
        gap_cnt_n  = GW'(IDLE_GAP);
      end
    end
  end

  // Line value is built from next-state so man/tx_en land in the cycle after accept.
  always_comb begin
    case (state_n)
      PRE:     nrz_n = ~bit_cnt_n[0];
      DATA:    nrz_n = sreg_n[0];
      PAR:     nrz_n = par_n;
      default: nrz_n = 1'b0;
    endcase
    tx_en_n = (state_n == PRE) || (state_n == DATA) || (state_n == PAR);
  end

  man_encoder_hb u_enc (
    .nrz   (nrz_n),
    .phase (phase_n),
    .man   (enc_man)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      sreg     <= '0;
      par      <= 1'b0;
      gap_cnt  <= '0;
      rst_done <= 1'b0;
      man      <= 1'b0;
      tx_en    <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      sreg     <= sreg_n;
      par      <= par_n;
      gap_cnt  <= gap_cnt_n;
      rst_done <= 1'b1;
      man      <= tx_en_n & enc_man;
      tx_en    <= tx_en_n;
    end
  end

  assign busy = (state != IDLE);
endmodule
